// File: rtl/sqrt_req_arbiter.sv
// Round-robin front end that shares a single square-root unit between N_REQ requesters,
// with negative-operand rejection and a watchdog that flushes a hung unit.
module sqrt_req_arbiter #(
   parameter int N_REQ   = 4,
   parameter int S_W     = 8,
   parameter int RES_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_i,
   input  logic [N_REQ*S_W-1:0]     sig_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic                     busy_o,
   output logic                     sqrt_do_o,
   output logic [S_W-1:0]           sqrt_s_o,
   output logic                     sqrt_flush_o,
   input  logic                     sqrt_valid_i,
   input  logic [RES_W-1:0]         sqrt_res_i,
   output logic [N_REQ-1:0]         done_o,
   output logic [$clog2(N_REQ)-1:0] id_o,
   output logic [RES_W-1:0]         res_o,
   output logic                     err_o
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REJECT} state_t;

   state_t             state_q;
   logic [ID_W-1:0]    rr_ptr_q;
   logic [ID_W-1:0]    id_q;
   logic [S_W-1:0]     op_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               do_q;
   logic               flush_q;
   logic [N_REQ-1:0]   done_q;
   logic [ID_W-1:0]    out_id_q;
   logic [RES_W-1:0]   res_q;
   logic               err_q;

   logic [N_REQ-1:0]   gnt_d;
   logic [ID_W-1:0]    gnt_id_d;
   logic               gnt_any_d;
   logic [S_W-1:0]     gnt_sig_d;

   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_REQ) s = s - N_REQ;
      return s[ID_W-1:0];
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // First requester at or after rr_ptr (with wrap) wins; only offered while idle.
   always_comb begin
      gnt_d     = '0;
      gnt_id_d  = '0;
      gnt_any_d = 1'b0;
      if (state_q == IDLE && !rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_any_d && req_i[wrap_add(rr_ptr_q, i)]) begin
               gnt_any_d = 1'b1;
               gnt_id_d  = wrap_add(rr_ptr_q, i);
            end
         end
         if (gnt_any_d) gnt_d = onehot(gnt_id_d);
      end
   end

   assign gnt_sig_d = sig_i[gnt_id_d*S_W +: S_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         do_q     <= 1'b0;
         flush_q  <= 1'b0;
         done_q   <= '0;
         out_id_q <= '0;
         res_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         do_q     <= 1'b0;
         flush_q  <= 1'b0;
         done_q   <= '0;
         out_id_q <= '0;
         res_q    <= '0;
         err_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (gnt_any_d) begin
                  op_q <= gnt_sig_d;
                  id_q <= gnt_id_d;
                  if (gnt_sig_d[S_W-1]) begin
                     state_q <= REJECT;
                  end else begin
                     state_q <= ISSUE;
                     do_q    <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               state_q <= WAIT;
               cnt_q   <= '0;
            end
            WAIT: begin
               // A valid arriving on the last allowed cycle still counts as success.
               if (sqrt_valid_i) begin
                  state_q  <= IDLE;
                  done_q   <= onehot(id_q);
                  out_id_q <= id_q;
                  res_q    <= sqrt_res_i;
                  rr_ptr_q <= wrap_add(id_q, 1);
               end else if (cnt_q == CNT_LAST) begin
                  state_q  <= IDLE;
                  done_q   <= onehot(id_q);
                  out_id_q <= id_q;
                  err_q    <= 1'b1;
                  flush_q  <= 1'b1;
                  rr_ptr_q <= wrap_add(id_q, 1);
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            REJECT: begin
               state_q  <= IDLE;
               done_q   <= onehot(id_q);
               out_id_q <= id_q;
               err_q    <= 1'b1;
               rr_ptr_q <= wrap_add(id_q, 1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt_o        = gnt_d;
   assign busy_o       = (state_q != IDLE);
   assign sqrt_do_o    = do_q;
   assign sqrt_s_o     = op_q;
   assign sqrt_flush_o = flush_q | rst;
   assign done_o       = done_q;
   assign id_o         = out_id_q;
   assign res_o        = res_q;
   assign err_o        = err_q;

endmodule
